fpio_fifo_wm: RTL and testbench

//  Single-clock FIFO for the fpio datapath. Second generation of the fpio FIFO, built with flat ports.

---
 rtl/fpio_fifo_pkg.sv | 13 +
 rtl/fpio_fifo_mem.sv | 31 +++
 rtl/fpio_fifo_wm.sv | 134 +++++++++++++
 tb/tb_fpio_fifo_wm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fpio_fifo_pkg.sv
// Shared types and helpers for the fpio FIFO family.
package fpio_fifo_pkg;

  typedef struct packed {
    logic ovf;
    logic udf;
  } fpio_fifo_err_t;

  function automatic int fpio_fifo_depth(input int bits);
    return 1 << bits;
  endfunction

endpackage

// File: rtl/fpio_fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read with read enable.
// The read register resets to zero and holds its value while re is low.
module fpio_fifo_mem #(
  parameter int ADDR_BITS  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fpio_fifo_wm.sv
// Single-clock fpio FIFO with full/empty protection, sticky errors, flush and
// optional watermarks (enabled by defining FPIO_FIFO_WATERMARK_EN).
module fpio_fifo_wm
  import fpio_fifo_pkg::*;
#(
  parameter int FIFO_BITS  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_data_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_data_ack,
  output logic [FIFO_BITS:0]    in_avail,
  input  logic                  out_data_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_data_ack,
  output logic [FIFO_BITS:0]    out_avail,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic                  ovf,
  output logic                  udf
`ifdef FPIO_FIFO_WATERMARK_EN
  ,
  input  logic [FIFO_BITS:0]    cfg_wm_hi,
  input  logic [FIFO_BITS:0]    cfg_wm_lo,
  output logic                  wm_hi,
  output logic                  wm_lo
`endif
);

  localparam int                 DEPTH   = fpio_fifo_depth(FIFO_BITS);
  localparam logic [FIFO_BITS:0] DEPTH_C = DEPTH[FIFO_BITS:0];
  localparam logic [FIFO_BITS:0] CNT_ONE = 1;
  localparam logic [FIFO_BITS-1:0] PTR_ONE = 1;

  // Handshake: a request on *_data_en is sampled at a posedge against the
  // registered count; if accepted, the matching *_ack is high for exactly
  // the following cycle. Rejected requests never ack; flush suppresses both.
  logic [FIFO_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_BITS:0]   count_q, count_d;
  logic                 in_ack_q, out_ack_q;
  fpio_fifo_err_t       err_q, err_d;

  logic push_req, pop_req, push_ok, pop_ok;

  assign push_req = in_data_en  & ~flush;
  assign pop_req  = out_data_en & ~flush;
  assign push_ok  = push_req && (count_q != DEPTH_C);
  assign pop_ok   = pop_req  && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
      else if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
    end
  end

  // A new error event wins over a clear arriving in the same cycle.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = '0;
    if (push_req && (count_q == DEPTH_C)) err_d.ovf = 1'b1;
    if (pop_req  && (count_q == '0))      err_d.udf = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      in_ack_q  <= 1'b0;
      out_ack_q <= 1'b0;
      err_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      in_ack_q  <= push_ok;
      out_ack_q <= pop_ok;
      err_q     <= err_d;
    end
  end

  fpio_fifo_mem #(
    .ADDR_BITS  (FIFO_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .re    (pop_ok),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

  assign in_data_ack  = in_ack_q;
  assign out_data_ack = out_ack_q;
  assign in_avail     = DEPTH_C - count_q;
  assign out_avail    = count_q;
  assign ovf          = err_q.ovf;
  assign udf          = err_q.udf;

`ifdef FPIO_FIFO_WATERMARK_EN
  // Flags are computed from next-count so they line up with out_avail.
  logic wm_hi_q, wm_lo_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wm_hi_q <= 1'b0;
      wm_lo_q <= 1'b1;
    end else begin
      wm_hi_q <= (count_d >= cfg_wm_hi);
      wm_lo_q <= (count_d <= cfg_wm_lo);
    end
  end

  assign wm_hi = wm_hi_q;
  assign wm_lo = wm_lo_q;
`endif

endmodule

// File: tb/tb_fpio_fifo_wm.sv
// Directed plus randomized bench for fpio_fifo_wm (DEPTH=4, 8-bit data),
// checked against a queue-based behavioural model.
module tb_fpio_fifo_wm;

  localparam int FB    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          in_data_en = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_data_ack;
  logic [FB:0]   in_avail;
  logic          out_data_en = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_data_ack;
  logic [FB:0]   out_avail;
  logic          flush = 1'b0;
  logic          err_clr = 1'b0;
  logic          ovf, udf;
`ifdef FPIO_FIFO_WATERMARK_EN
  logic [FB:0]   cfg_wm_hi = 3'd3;
  logic [FB:0]   cfg_wm_lo = 3'd1;
  logic          wm_hi, wm_lo;
`endif

  fpio_fifo_wm #(.FIFO_BITS(FB), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_data_en   (in_data_en),
    .in_data      (in_data),
    .in_data_ack  (in_data_ack),
    .in_avail     (in_avail),
    .out_data_en  (out_data_en),
    .out_data     (out_data),
    .out_data_ack (out_data_ack),
    .out_avail    (out_avail),
    .flush        (flush),
    .err_clr      (err_clr),
    .ovf          (ovf),
    .udf          (udf)
`ifdef FPIO_FIFO_WATERMARK_EN
    ,
    .cfg_wm_hi    (cfg_wm_hi),
    .cfg_wm_lo    (cfg_wm_lo),
    .wm_hi        (wm_hi),
    .wm_lo        (wm_lo)
`endif
  );

  // scoreboard / reference model
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_out;
  logic          exp_in_ack, exp_out_ack, exp_ovf, exp_udf, exp_wm_hi, exp_wm_lo;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_out = '0;
    exp_in_ack = 1'b0;
    exp_out_ack = 1'b0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    exp_wm_hi = 1'b0;
    exp_wm_lo = 1'b1;
  endtask

  task automatic model_step(input logic push, input logic [DW-1:0] d, input logic pop,
                            input logic fl, input logic clr);
    bit was_full, was_empty;
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    if (clr) begin
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end
    if (fl) begin
      exp_q.delete();
      exp_in_ack = 1'b0;
      exp_out_ack = 1'b0;
    end else begin
      exp_in_ack  = push && !was_full;
      exp_out_ack = pop && !was_empty;
      if (push && was_full) exp_ovf = 1'b1;
      if (pop && was_empty) exp_udf = 1'b1;
      if (exp_out_ack) exp_out = exp_q.pop_front();
      if (exp_in_ack) exp_q.push_back(d);
    end
    exp_wm_hi = (exp_q.size() >= 3);
    exp_wm_lo = (exp_q.size() <= 1);
  endtask

  task automatic check_all();
    chk("in_data_ack", in_data_ack, exp_in_ack);
    chk("out_data_ack", out_data_ack, exp_out_ack);
    chk("out_avail", out_avail, exp_q.size());
    chk("in_avail", in_avail, DEPTH - exp_q.size());
    chk("out_data", out_data, exp_out);
    chk("ovf", ovf, exp_ovf);
    chk("udf", udf, exp_udf);
`ifdef FPIO_FIFO_WATERMARK_EN
    chk("wm_hi", wm_hi, exp_wm_hi);
    chk("wm_lo", wm_lo, exp_wm_lo);
`endif
  endtask

  // driver: apply one cycle of requests, then check #1 after the edge
  task automatic step(input logic push, input logic [DW-1:0] d, input logic pop,
                      input logic fl, input logic clr);
    @(negedge clk);
    in_data_en  = push;
    in_data     = d;
    out_data_en = pop;
    flush       = fl;
    err_clr     = clr;
    @(posedge clk);
    model_step(push, d, pop, fl, clr);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    in_data_en  = 1'b0;
    out_data_en = 1'b0;
    flush       = 1'b0;
    err_clr     = 1'b0;
  endtask

  initial begin
    // reset
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rstn = 1'b1;

    // basic push/pop
    step(1, 8'hA1, 0, 0, 0);
    step(1, 8'hA2, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // fill, overflow, drain, clear
    for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
    step(1, 8'h14, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);

    // underflow, then push+pop while empty
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'h55, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);

    // fill to 3, then streaming push+pop across pointer wrap
    step(1, 8'h61, 0, 0, 0);
    step(1, 8'h62, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 8'($urandom_range(0, 255)), 1, 0, 0);

    // push+pop while full
    step(1, 8'h70, 0, 0, 0);
    step(1, 8'h71, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);

    // count=2 then flush with push+pop asserted
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'h80, 1, 1, 0);
    step(0, 8'h00, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));

    // mid-stream asynchronous reset at count=2 with errors set
    step(0, 8'h00, 0, 1, 1);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'h91, 0, 0, 0);
    step(1, 8'h92, 0, 0, 0);
    @(negedge clk);
    idle_inputs();
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rstn = 1'b1;

    // traffic after reset
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           1'b0, ($urandom_range(0, 9) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
